drum_sector_decoder: RTL and testbench

- Read-side decoder for the drum timing tracks: recovers word framing from the Z2 sector-mark track and the serial sector address from the Z3 address track.
- Sits between the drum model / drum read amplifiers and the control logic.
- Provides bit position, current word address, index indication, and a search-and-match handshake, so control logic can wait for a requested drum word.

---
 rtl/drum_sector_decoder_pkg.sv | 32 +++
 rtl/drum_sector_decoder_if.sv | 27 ++
 rtl/drum_frame_sync.sv | 77 +++++++
 rtl/drum_sector_decoder.sv | 109 ++++++++++
 tb/tb_drum_sector_decoder.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/drum_sector_decoder_pkg.sv
// Shared constants, types and the Z2 sector-mark pattern for the drum sector decoder.
package drum_sector_decoder_pkg;
  localparam int WORD_BITS  = 40;
  localparam int ADDR_BITS  = 7;
  localparam int ADDR_POS   = 32;
  localparam int LOCK_WORDS = 2;
  localparam int CNT_W      = 6;
  localparam int GOOD_W     = $clog2(LOCK_WORDS + 1);

  typedef logic [CNT_W-1:0]     bitpos_t;
  typedef logic [ADDR_BITS-1:0] addr_t;
  typedef logic [GOOD_W-1:0]    good_t;

  localparam bitpos_t LAST_BIT   = bitpos_t'(WORD_BITS - 1);
  localparam bitpos_t ADDR_FIRST = bitpos_t'(ADDR_POS);
  localparam bitpos_t ADDR_LAST  = bitpos_t'(ADDR_POS + ADDR_BITS - 1);
  localparam bitpos_t MARK_A_LO  = bitpos_t'(31);
  localparam bitpos_t MARK_A_HI  = bitpos_t'(33);
  localparam bitpos_t MARK_B_LO  = bitpos_t'(38);
  localparam bitpos_t BIT_ONE    = bitpos_t'(1);
  localparam addr_t   ADDR_ONE   = addr_t'(1);
  localparam good_t   GOOD_ONE   = good_t'(1);
  localparam good_t   LOCK_LAST  = good_t'(LOCK_WORDS - 1);

  typedef enum logic [1:0] {S_HUNT, S_VERIFY, S_LOCKED} sync_state_t;

  // Z2 is high at the address-window mark and at the two-bit frame marker.
  function automatic logic z2_expected(input bitpos_t pos);
    return ((pos >= MARK_A_LO) && (pos <= MARK_A_HI)) ||
           ((pos >= MARK_B_LO) && (pos <= LAST_BIT));
  endfunction
endpackage

// File: rtl/drum_sector_decoder_if.sv
// Drum-track / control-side bundle of the sector decoder.
interface drum_sector_decoder_if;
  import drum_sector_decoder_pkg::*;

  logic    Z2;
  logic    Z3;
  logic    SEARCH;
  addr_t   TARGET;
  logic    LOCKED;
  bitpos_t BITCNT;
  addr_t   ADDR;
  logic    WORD_END;
  logic    INDEX;
  logic    FOUND;
  logic    SYNC_ERR;
  logic    SEQ_ERR;

  modport master (
    output Z2, Z3, SEARCH, TARGET,
    input  LOCKED, BITCNT, ADDR, WORD_END, INDEX, FOUND, SYNC_ERR, SEQ_ERR
  );

  modport slave (
    input  Z2, Z3, SEARCH, TARGET,
    output LOCKED, BITCNT, ADDR, WORD_END, INDEX, FOUND, SYNC_ERR, SEQ_ERR
  );
endinterface

// File: rtl/drum_frame_sync.sv
// Word framing from the Z2 track: marker hunt, bit counter, pattern check and lock state.
module drum_frame_sync
  import drum_sector_decoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        z2,
  output sync_state_t state_q,
  output bitpos_t     bitcnt_q,
  output bitpos_t     pos,
  output logic        bit_ok,
  output logic        violation,
  output logic        sync_err_q
);
  sync_state_t state_d;
  bitpos_t     bitcnt_d;
  logic [1:0]  run_q, run_d;
  good_t       good_q, good_d;
  logic        sync_err_d;

  always_comb begin
    // pos is the position of the bit being sampled on this edge
    pos        = (bitcnt_q == LAST_BIT) ? '0 : bitpos_t'(bitcnt_q + BIT_ONE);
    violation  = (state_q != S_HUNT) && (z2 != z2_expected(pos));
    bit_ok     = (state_q != S_HUNT) && !violation;
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    run_d      = run_q;
    good_d     = good_q;
    sync_err_d = 1'b0;
    case (state_q)
      S_HUNT: begin
        bitcnt_d = '0;
        if (z2) begin
          run_d = (run_q == 2'd3) ? 2'd3 : run_q + 2'd1;
        end else begin
          run_d = 2'd0;
          // exactly two highs then a low: this low sample is bit 0
          if (run_q == 2'd2) begin
            state_d = S_VERIFY;
            good_d  = '0;
          end
        end
      end
      default: begin
        if (violation) begin
          state_d    = S_HUNT;
          sync_err_d = 1'b1;
          bitcnt_d   = '0;
          run_d      = z2 ? 2'd1 : 2'd0;
        end else begin
          bitcnt_d = pos;
          if (state_q == S_VERIFY && pos == LAST_BIT) begin
            if (good_q == LOCK_LAST) state_d = S_LOCKED;
            else                     good_d  = good_q + GOOD_ONE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_HUNT;
      bitcnt_q   <= '0;
      run_q      <= 2'd0;
      good_q     <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      run_q      <= run_d;
      good_q     <= good_d;
      sync_err_q <= sync_err_d;
    end
  end
endmodule

// File: rtl/drum_sector_decoder.sv
// Drum read-side decoder: Z3 address capture, sequence/index checking and target search.
module drum_sector_decoder
  import drum_sector_decoder_pkg::*;
(
  input logic                  Z1,
  input logic                  CLR,
  drum_sector_decoder_if.slave bus
);
  sync_state_t state_q;
  bitpos_t     bitcnt_q, pos;
  logic        bit_ok, violation, sync_err_q;

  drum_frame_sync u_sync (
    .clk        (Z1),
    .rst_n      (CLR),
    .z2         (bus.Z2),
    .state_q    (state_q),
    .bitcnt_q   (bitcnt_q),
    .pos        (pos),
    .bit_ok     (bit_ok),
    .violation  (violation),
    .sync_err_q (sync_err_q)
  );

  addr_t sreg_q, sreg_d, addr_q, addr_d, target_q, target_d, next_addr;
  logic  word_end_q, word_end_d, index_q, index_d, found_q, found_d;
  logic  seq_err_q, seq_err_d, first_q, first_d;
  logic  search_q, search_d, armed_q, armed_d;
  logic  word_end, locked_end;

  always_comb begin
    sreg_d     = sreg_q;
    addr_d     = addr_q;
    target_d   = target_q;
    word_end_d = 1'b0;
    index_d    = 1'b0;
    found_d    = 1'b0;
    seq_err_d  = 1'b0;
    first_d    = first_q;
    search_d   = bus.SEARCH;
    armed_d    = armed_q;
    word_end   = bit_ok && (pos == LAST_BIT);
    locked_end = word_end && (state_q == S_LOCKED);
    next_addr  = addr_t'(addr_q + ADDR_ONE);

    if (bit_ok && (pos >= ADDR_FIRST) && (pos <= ADDR_LAST))
      sreg_d = {bus.Z3, sreg_q[ADDR_BITS-1:1]};

    if (word_end) begin
      addr_d     = sreg_q;
      word_end_d = 1'b1;
      index_d    = bus.Z3;
    end

    // first locked word has no trustworthy predecessor for the +1 check
    if (state_q != S_LOCKED) first_d = 1'b1;
    if (locked_end) begin
      seq_err_d = (!first_q && (sreg_q != next_addr)) || (bus.Z3 != (sreg_q == '0));
      first_d   = 1'b0;
      if (armed_q && (sreg_q == target_q)) begin
        found_d = 1'b1;
        armed_d = 1'b0;
      end
    end

    if (bus.SEARCH && !search_q) begin
      armed_d  = 1'b1;
      target_d = bus.TARGET;
    end else if (!bus.SEARCH && search_q) begin
      armed_d = 1'b0;
    end
    if (violation) armed_d = 1'b0;
  end

  always_ff @(posedge Z1 or negedge CLR) begin
    if (!CLR) begin
      sreg_q     <= '0;
      addr_q     <= '0;
      target_q   <= '0;
      word_end_q <= 1'b0;
      index_q    <= 1'b0;
      found_q    <= 1'b0;
      seq_err_q  <= 1'b0;
      first_q    <= 1'b1;
      search_q   <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      sreg_q     <= sreg_d;
      addr_q     <= addr_d;
      target_q   <= target_d;
      word_end_q <= word_end_d;
      index_q    <= index_d;
      found_q    <= found_d;
      seq_err_q  <= seq_err_d;
      first_q    <= first_d;
      search_q   <= search_d;
      armed_q    <= armed_d;
    end
  end

  assign bus.LOCKED   = (state_q == S_LOCKED);
  assign bus.BITCNT   = bitcnt_q;
  assign bus.ADDR     = addr_q;
  assign bus.WORD_END = word_end_q;
  assign bus.INDEX    = index_q;
  assign bus.FOUND    = found_q;
  assign bus.SYNC_ERR = sync_err_q;
  assign bus.SEQ_ERR  = seq_err_q;
endmodule

// File: tb/tb_drum_sector_decoder.sv
// Directed bench: synthetic drum words drive Z2/Z3; outputs checked against hand-derived values.
module tb_drum_sector_decoder;
  logic Z1 = 1'b0;
  logic CLR;

  drum_sector_decoder_if bus();

  drum_sector_decoder dut (
    .Z1  (Z1),
    .CLR (CLR),
    .bus (bus)
  );

  always #5 Z1 = ~Z1;

  int checks = 0;
  int errors = 0;
  int we_cnt, found_cnt, seq_cnt, sync_cnt, idx_cnt, bc_bad;
  int t_found, t_seq, t_sync, t_bc, t_we;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_cnt();
    we_cnt = 0; found_cnt = 0; seq_cnt = 0; sync_cnt = 0; idx_cnt = 0; bc_bad = 0;
  endtask

  // Drive bits [from..to] of drum word a; kill inverts Z2, flip inverts Z3 at that bit.
  task automatic drum_bits(input int a, input int from, input int to, input int kill, input int flip);
    logic [6:0] av;
    logic z2, z3;
    av = 7'(a);
    for (int i = from; i <= to; i++) begin
      z2 = ((i >= 31) && (i <= 33)) || (i >= 38);
      if (i == kill) z2 = ~z2;
      if (i >= 32 && i <= 38) z3 = av[i-32];
      else if (i == 39)       z3 = (av == 7'd0);
      else                    z3 = 1'($urandom);
      if (i == flip) z3 = ~z3;
      bus.Z2 = z2;
      bus.Z3 = z3;
      @(posedge Z1);
      #1;
      we_cnt    += int'(bus.WORD_END);
      found_cnt += int'(bus.FOUND);
      seq_cnt   += int'(bus.SEQ_ERR);
      sync_cnt  += int'(bus.SYNC_ERR);
      idx_cnt   += int'(bus.INDEX);
      if (bus.LOCKED && (bus.BITCNT != 6'(i))) bc_bad++;
    end
  endtask

  task automatic word(input int a, input int kill = -1, input int flip = -1);
    clr_cnt();
    drum_bits(a, 0, 39, kill, flip);
  endtask

  task automatic tot_clr();
    t_found = 0; t_seq = 0; t_sync = 0; t_bc = 0; t_we = 0;
  endtask

  task automatic tot_acc();
    t_found += found_cnt; t_seq += seq_cnt; t_sync += sync_cnt; t_bc += bc_bad; t_we += we_cnt;
  endtask

  initial begin
    CLR = 1'b0;
    bus.Z2 = 1'b0; bus.Z3 = 1'b0; bus.SEARCH = 1'b0; bus.TARGET = '0;
    repeat (2) @(posedge Z1);
    #1;
    chk("rst_locked",   bus.LOCKED,   0);
    chk("rst_bitcnt",   bus.BITCNT,   0);
    chk("rst_addr",     bus.ADDR,     0);
    chk("rst_word_end", bus.WORD_END, 0);
    chk("rst_index",    bus.INDEX,    0);
    chk("rst_found",    bus.FOUND,    0);
    chk("rst_sync_err", bus.SYNC_ERR, 0);
    chk("rst_seq_err",  bus.SEQ_ERR,  0);
    CLR = 1'b1;

    // acquisition: marker at end of word 0, lock at end of word 2
    word(0);
    chk("w0_locked", bus.LOCKED, 0);
    chk("w0_we",     we_cnt,     0);
    word(1);
    chk("w1_locked", bus.LOCKED, 0);
    chk("w1_addr",   bus.ADDR,   1);
    chk("w1_we",     we_cnt,     1);
    word(2);
    chk("w2_locked", bus.LOCKED, 1);
    chk("w2_addr",   bus.ADDR,   2);
    word(3);
    chk("w3_addr",   bus.ADDR,     3);
    chk("w3_we",     bus.WORD_END, 1);
    chk("w3_index",  bus.INDEX,    0);
    chk("w3_seq",    seq_cnt,      0);
    chk("w3_bitcnt", bc_bad,       0);
    word(4);
    chk("w4_addr",   bus.ADDR, 4);

    // search for 10 starting from word 4
    bus.SEARCH = 1'b1; bus.TARGET = 7'd10;
    tot_clr();
    for (int a = 5; a <= 9; a++) begin word(a); tot_acc(); end
    chk("srch_early_found", t_found, 0);
    word(10);
    chk("srch_found",      bus.FOUND, 1);
    chk("srch_found_addr", bus.ADDR,  10);
    chk("srch_found_cnt",  found_cnt, 1);

    tot_clr();
    for (int a = 11; a <= 126; a++) begin word(a); tot_acc(); end
    chk("run_found", t_found, 0);
    chk("run_seq",   t_seq,   0);
    chk("run_sync",  t_sync,  0);
    chk("run_bc",    t_bc,    0);
    chk("run_we",    t_we,    116);
    word(127);
    chk("w127_addr",  bus.ADDR,    127);
    chk("w127_index", bus.INDEX,   0);
    chk("w127_seq",   bus.SEQ_ERR, 0);
    word(0);
    chk("wrap_addr",  bus.ADDR,    0);
    chk("wrap_index", bus.INDEX,   1);
    chk("wrap_seq",   bus.SEQ_ERR, 0);
    tot_clr();
    for (int a = 1; a <= 10; a++) begin word(a); tot_acc(); end
    chk("rev2_found", t_found,  0);
    chk("rev2_addr",  bus.ADDR, 10);

    // Z2 violation at bit 32 while armed for 16
    bus.SEARCH = 1'b0;
    word(11);
    bus.SEARCH = 1'b1; bus.TARGET = 7'd16;
    word(12, 32);
    chk("se_sync",   sync_cnt,   1);
    chk("se_locked", bus.LOCKED, 0);
    chk("se_we",     we_cnt,     0);
    chk("se_addr",   bus.ADDR,   11);
    word(13);
    chk("re_w13_locked", bus.LOCKED, 0);
    chk("re_w13_addr",   bus.ADDR,   13);
    word(14);
    chk("re_w14_locked", bus.LOCKED, 1);
    tot_clr();
    for (int a = 15; a <= 17; a++) begin word(a); tot_acc(); end
    chk("re_disarmed", t_found, 0);
    chk("re_seq",      t_seq,   0);
    bus.SEARCH = 1'b0;

    // address bit 3 corrupted, then index bit corrupted
    word(18);
    word(19);
    word(20, -1, 35);
    chk("flip_addr",   bus.ADDR,    28);
    chk("flip_seq",    bus.SEQ_ERR, 1);
    chk("flip_locked", bus.LOCKED,  1);
    word(21);
    chk("flip_next_addr", bus.ADDR,    21);
    chk("flip_next_seq",  bus.SEQ_ERR, 1);
    word(22);
    chk("flip_clean_seq", bus.SEQ_ERR, 0);
    word(23, -1, 39);
    chk("idx_flip_index", bus.INDEX,   1);
    chk("idx_flip_seq",   bus.SEQ_ERR, 1);
    word(24);
    chk("idx_clean_seq",  seq_cnt, 0);
    chk("idx_clean_idx",  idx_cnt, 0);

    // reset at bit 20 while locked and armed
    bus.SEARCH = 1'b1; bus.TARGET = 7'd28;
    clr_cnt();
    drum_bits(25, 0, 19, -1, -1);
    CLR = 1'b0;
    #1;
    chk("clr_locked",   bus.LOCKED,   0);
    chk("clr_bitcnt",   bus.BITCNT,   0);
    chk("clr_addr",     bus.ADDR,     0);
    chk("clr_word_end", bus.WORD_END, 0);
    bus.SEARCH = 1'b0;
    drum_bits(25, 20, 24, -1, -1);
    CLR = 1'b1;
    drum_bits(25, 25, 39, -1, -1);
    chk("clr_w25_locked", bus.LOCKED, 0);
    chk("clr_w25_we",     we_cnt,     0);
    word(26);
    chk("clr_w26_locked", bus.LOCKED, 0);
    chk("clr_w26_addr",   bus.ADDR,   26);
    word(27);
    chk("clr_w27_locked", bus.LOCKED, 1);
    tot_clr();
    for (int a = 28; a <= 29; a++) begin word(a); tot_acc(); end
    chk("clr_no_found", t_found, 0);
    bus.SEARCH = 1'b1; bus.TARGET = 7'd31;
    word(30);
    chk("new_srch_w30", found_cnt, 0);
    word(31);
    chk("new_srch_found", bus.FOUND, 1);
    chk("new_srch_addr",  bus.ADDR,  31);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
